// File: rtl/ex_mem_stage_pkg.sv
// ex_mem_stage_pkg
// Shared constants and helpers for the EX/MEM pipeline register.
// Holds the write/reset constants used by the rest of the core.
// Also holds the stall-vector indices and the per-register control decode.
package ex_mem_stage_pkg;

    localparam logic        RstEnable    = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;

    // Stall vector layout: pc, if, id, ex, mem, wb (bit 0 .. bit 5)
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;

    // What a pipeline register does on the next clock edge
    typedef enum logic [1:0] {
        PIPE_LOAD   = 2'd0,
        PIPE_HOLD   = 2'd1,
        PIPE_BUBBLE = 2'd2
    } pipe_ctrl_e;

    // Flush beats any stall. EX stalled with MEM free drains a bubble into MEM.
    // Any other stall combination holds.
    function automatic pipe_ctrl_e pipe_ctrl(input logic flush,
                                             input logic ex_stall,
                                             input logic mem_stall);
        pipe_ctrl_e c;
        if (flush)
            c = PIPE_BUBBLE;
        else if (ex_stall && !mem_stall)
            c = PIPE_BUBBLE;
        else if (ex_stall || mem_stall)
            c = PIPE_HOLD;
        else
            c = PIPE_LOAD;
        return c;
    endfunction

endpackage

// File: rtl/ex_mem_stage_pipe_bubble_reg.sv
// pipe_bubble_reg
// Generic pipeline register with load, hold and bubble-insert controls.
// A bubble loads BUBBLE_VAL, which is also the reset value.
module pipe_bubble_reg
    import ex_mem_stage_pkg::*;
#(
    parameter int            W          = 1,
    parameter logic [W-1:0]  BUBBLE_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  pipe_ctrl_e   ctrl,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Register update: reset, then load / bubble / hold as decoded upstream
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst == RstEnable) begin
            q <= BUBBLE_VAL;
        end else begin
            case (ctrl)
                PIPE_LOAD:   q <= d;
                PIPE_BUBBLE: q <= BUBBLE_VAL;
                default:     q <= q;
            endcase
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage
// EX/MEM pipeline register for the 5-stage MIPS core.
// It carries the GPR writeback descriptor and the HI/LO write triple.
// It also carries a valid flag. Bubbles are inserted on flush and on EX-only stalls.
// The hilo_temp/cnt loop-back keeps partial results of multi-cycle EX ops
// (madd/msub, div) alive while EX is stalled.
// Optional: define EX_MEM_BUBBLE_CNT_EN to add a saturating bubble_cnt output.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter int CNT_W         = 2,
    parameter int STALL_W       = 6,
    parameter int EX_STALL_BIT  = STALL_EX,
    parameter int MEM_STALL_BIT = STALL_MEM
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   ex_wd,
    input  logic                ex_wreg,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic                ex_whilo,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic [2*DATA_W-1:0] hilo_temp_i,
    input  logic [CNT_W-1:0]    cnt_i,
    output logic [ADDR_W-1:0]   mem_wd,
    output logic                mem_wreg,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_whilo,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic                mem_valid,
    output logic [2*DATA_W-1:0] hilo_temp_o,
    output logic [CNT_W-1:0]    cnt_o
`ifdef EX_MEM_BUBBLE_CNT_EN
    ,
    output logic [31:0]         bubble_cnt
`endif
);

    // {valid, wd, wreg, wdata}: a bubble is an invalid no-op write to $0
    localparam int WB_W = 1 + ADDR_W + 1 + DATA_W;
    localparam logic [WB_W-1:0] WB_BUBBLE =
        {1'b0, ADDR_W'(NOPRegAddr), WriteDisable, DATA_W'(ZeroWord)};

    // {whilo, hi, lo}
    localparam int HILO_W = 1 + 2 * DATA_W;
    localparam logic [HILO_W-1:0] HILO_BUBBLE =
        {WriteDisable, DATA_W'(ZeroWord), DATA_W'(ZeroWord)};

    logic ex_stall;
    logic mem_stall;
    pipe_ctrl_e ctrl;

    logic [WB_W-1:0]   wb_q;
    logic [HILO_W-1:0] hilo_q;

    // Only the EX and MEM bits matter here. The rest of the vector belongs to other stages.
    logic unused_stall_bits;
    assign unused_stall_bits = ^stall;

    assign ex_stall  = stall[EX_STALL_BIT];
    assign mem_stall = stall[MEM_STALL_BIT];
    assign ctrl      = pipe_ctrl(flush, ex_stall, mem_stall);

    pipe_bubble_reg #(
        .W          (WB_W),
        .BUBBLE_VAL (WB_BUBBLE)
    ) u_wb_reg (
        .clk  (clk),
        .rst  (rst),
        .ctrl (ctrl),
        .d    ({1'b1, ex_wd, ex_wreg, ex_wdata}),
        .q    (wb_q)
    );

    pipe_bubble_reg #(
        .W          (HILO_W),
        .BUBBLE_VAL (HILO_BUBBLE)
    ) u_hilo_reg (
        .clk  (clk),
        .rst  (rst),
        .ctrl (ctrl),
        .d    ({ex_whilo, ex_hi, ex_lo}),
        .q    (hilo_q)
    );

    assign {mem_valid, mem_wd, mem_wreg, mem_wdata} = wb_q;
    assign {mem_whilo, mem_hi, mem_lo}              = hilo_q;

    // Loop-back: keep EX's partial result only while EX is stalled and MEM drains.
    // Clear it whenever the op is killed or has left EX.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            hilo_temp_o <= '0;
            cnt_o       <= '0;
        end else if (flush) begin
            hilo_temp_o <= '0;
            cnt_o       <= '0;
        end else if (ex_stall && !mem_stall) begin
            hilo_temp_o <= hilo_temp_i;
            cnt_o       <= cnt_i;
        end else if (ex_stall || mem_stall) begin
            hilo_temp_o <= hilo_temp_o;
            cnt_o       <= cnt_o;
        end else begin
            hilo_temp_o <= '0;
            cnt_o       <= '0;
        end
    end

`ifdef EX_MEM_BUBBLE_CNT_EN
    // Count bubbles loaded into MEM, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst == RstEnable)
            bubble_cnt <= '0;
        else if (ctrl == PIPE_BUBBLE && bubble_cnt != 32'hFFFF_FFFF)
            bubble_cnt <= bubble_cnt + 32'd1;
    end
`endif

`ifndef SYNTHESIS
    // ctrl never stalls MEM while letting EX run
    illegal_stall_a: assert property (@(posedge clk) disable iff (rst)
        !(!ex_stall && mem_stall));
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage
// Scoreboard bench for ex_mem_stage.
// The driver applies stimulus on the falling edge. For each cycle it pushes the state
// a behavioural model predicts after the next rising edge.
// The monitor pops one prediction after every rising edge and compares it with the DUT outputs.
// Build with +define+EX_MEM_BUBBLE_CNT_EN to cover the bubble counter.
module tb_ex_mem_stage;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic        ex_whilo;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic [63:0] hilo_temp_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        mem_valid;
    logic [63:0] hilo_temp_o;
    logic [1:0]  cnt_o;
`ifdef EX_MEM_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt;
`endif

    ex_mem_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .ex_wd       (ex_wd),
        .ex_wreg     (ex_wreg),
        .ex_wdata    (ex_wdata),
        .ex_whilo    (ex_whilo),
        .ex_hi       (ex_hi),
        .ex_lo       (ex_lo),
        .hilo_temp_i (hilo_temp_i),
        .cnt_i       (cnt_i),
        .mem_wd      (mem_wd),
        .mem_wreg    (mem_wreg),
        .mem_wdata   (mem_wdata),
        .mem_whilo   (mem_whilo),
        .mem_hi      (mem_hi),
        .mem_lo      (mem_lo),
        .mem_valid   (mem_valid),
        .hilo_temp_o (hilo_temp_o),
        .cnt_o       (cnt_o)
`ifdef EX_MEM_BUBBLE_CNT_EN
        ,
        .bubble_cnt  (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic [5:0]  stall;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [63:0] hilo;
        logic [1:0]  cnt;
    } stim_t;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        valid;
        logic [63:0] hilo;
        logic [1:0]  cnt;
        logic [31:0] bcnt;
    } exp_t;

    exp_t q_exp[$];
    exp_t mdl;
    exp_t got;
    int   checks   = 0;
    int   failures = 0;

    // Legal stall vectors from ctrl: a stalled stage also stalls every earlier stage
    logic [5:0] legal_stall [6] = '{6'b000000, 6'b000011, 6'b000111,
                                    6'b001111, 6'b011111, 6'b111111};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: what MEM and the loop-back hold after one clock with stimulus s
    task automatic model_step(input stim_t s);
        logic ex_st;
        logic mem_st;
        ex_st  = s.stall[3];
        mem_st = s.stall[4];
        if (s.rst) begin
            mdl = '{default: '0};
        end else if (s.flush || (ex_st && !mem_st)) begin
            mdl.wd    = 5'd0;
            mdl.wreg  = 1'b0;
            mdl.wdata = 32'd0;
            mdl.whilo = 1'b0;
            mdl.hi    = 32'd0;
            mdl.lo    = 32'd0;
            mdl.valid = 1'b0;
            mdl.hilo  = s.flush ? 64'd0 : s.hilo;
            mdl.cnt   = s.flush ? 2'd0 : s.cnt;
            if (mdl.bcnt != 32'hFFFF_FFFF)
                mdl.bcnt = mdl.bcnt + 1;
        end else if (ex_st || mem_st) begin
            mdl = mdl;
        end else begin
            mdl.wd    = s.wd;
            mdl.wreg  = s.wreg;
            mdl.wdata = s.wdata;
            mdl.whilo = s.whilo;
            mdl.hi    = s.hi;
            mdl.lo    = s.lo;
            mdl.valid = 1'b1;
            mdl.hilo  = 64'd0;
            mdl.cnt   = 2'd0;
        end
    endtask

    task automatic drive(input stim_t s);
        @(negedge clk);
        rst         = s.rst;
        flush       = s.flush;
        stall       = s.stall;
        ex_wd       = s.wd;
        ex_wreg     = s.wreg;
        ex_wdata    = s.wdata;
        ex_whilo    = s.whilo;
        ex_hi       = s.hi;
        ex_lo       = s.lo;
        hilo_temp_i = s.hilo;
        cnt_i       = s.cnt;
        model_step(s);
        q_exp.push_back(mdl);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst   = ($urandom_range(0, 99) < 3);
        s.flush = ($urandom_range(0, 99) < 10);
        s.stall = legal_stall[$urandom_range(0, 5)];
        s.wd    = 5'($urandom);
        s.wreg  = 1'($urandom);
        s.wdata = $urandom;
        s.whilo = 1'($urandom);
        s.hi    = $urandom;
        s.lo    = $urandom;
        s.hilo  = {$urandom, $urandom};
        s.cnt   = 2'($urandom);
        return s;
    endfunction

    // Monitor: one prediction per rising edge, sampled just after the edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() > 0) begin
                got = q_exp.pop_front();
                check("mem_wd",      64'(mem_wd),    64'(got.wd));
                check("mem_wreg",    64'(mem_wreg),  64'(got.wreg));
                check("mem_wdata",   64'(mem_wdata), 64'(got.wdata));
                check("mem_whilo",   64'(mem_whilo), 64'(got.whilo));
                check("mem_hi",      64'(mem_hi),    64'(got.hi));
                check("mem_lo",      64'(mem_lo),    64'(got.lo));
                check("mem_valid",   64'(mem_valid), 64'(got.valid));
                check("hilo_temp_o", hilo_temp_o,    got.hilo);
                check("cnt_o",       64'(cnt_o),     64'(got.cnt));
`ifdef EX_MEM_BUBBLE_CNT_EN
                check("bubble_cnt",  64'(bubble_cnt), 64'(got.bcnt));
`endif
            end
        end
    end

    initial begin
        stim_t s;
        mdl = '{default: '0};
        rst = 1'b1; flush = 1'b0; stall = '0;
        ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0; ex_whilo = 1'b0;
        ex_hi = '0; ex_lo = '0; hilo_temp_i = '0; cnt_i = '0;

        // Reset held two cycles with nonzero inputs
        s = '{rst: 1'b1, flush: 1'b0, stall: 6'b000000, wd: 5'd31, wreg: 1'b1,
              wdata: 32'hFFFF_FFFF, whilo: 1'b1, hi: 32'h1111_1111, lo: 32'h2222_2222,
              hilo: 64'h3333_3333_4444_4444, cnt: 2'd3};
        drive(s);
        drive(s);

        // Normal flow
        s = idle(); s.wd = 5'd8; s.wreg = 1'b1; s.wdata = 32'h1234_5678;
        drive(s);

        // EX stall only: bubble into MEM, loop-back captured
        s = idle(); s.stall = 6'b001111; s.hilo = 64'hA5; s.cnt = 2'd1;
        drive(s);

        // Full hold after a normal load: three unchanged cycles
        s = idle(); s.wd = 5'd8; s.wreg = 1'b1; s.wdata = 32'h1234_5678;
        drive(s);
        s = idle(); s.stall = 6'b001111; s.hilo = 64'h5A; s.cnt = 2'd2;
        drive(s);
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.stall = 6'b011111; s.wd = 5'd3; s.wreg = 1'b1;
            s.wdata = 32'hCAFE_0000 + 32'(i); s.hilo = 64'hFFFF; s.cnt = 2'd3;
            drive(s);
        end

        // Flush overrides the EX stall and clears loop-back
        s = idle(); s.flush = 1'b1; s.stall = 6'b001111; s.hilo = 64'hA5; s.cnt = 2'd1;
        drive(s);

        // HI/LO path
        s = idle(); s.whilo = 1'b1; s.hi = 32'hDEAD_BEEF; s.lo = 32'h0000_0001;
        drive(s);

        // Bubble count: after reset, three stall bubbles and one flush give four
        s = idle(); s.rst = 1'b1;
        drive(s);
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.stall = 6'b001111; s.hilo = 64'(i + 1); s.cnt = 2'(i);
            drive(s);
        end
        s = idle(); s.flush = 1'b1;
        drive(s);

        // Randomised legal traffic
        for (int i = 0; i < 400; i++)
            drive(rand_stim());

        s = idle();
        drive(s);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 20 && q_exp.size() > 0; i++)
            @(negedge clk);
        if (q_exp.size() > 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0 pending", q_exp.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
Parametrised EX/MEM pipeline register for the 5-stage MIPS core. It carries the writeback descriptor (dest, enable, data) and the HI/LO write triple from EX to MEM.
Adds what the plain EX/MEM latch lacks:
- stall-vector handling with bubble insertion
- synchronous flush
- a valid flag
- a loop-back path (hilo_temp/cnt) that preserves partial results of multi-cycle EX ops (madd/msub, div) across EX stalls

Parameters:
DATA_W, 32, GPR/HI/LO data width
ADDR_W, 5, register-file address width
CNT_W, 2, width of multi-cycle step counter
STALL_W, 6, width of pipeline stall vector (pc, if, id, ex, mem, wb)
EX_STALL_BIT, 3, stall index of EX stage
MEM_STALL_BIT, 4, stall index of MEM stage

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
stall  in  STALL_W  per-stage stall request from ctrl
flush  in  1  kill in-flight instruction (exception)
ex_wd  in  ADDR_W  destination register
ex_wreg  in  1  GPR write enable
ex_wdata  in  DATA_W  GPR write data
ex_whilo  in  1  HI/LO write enable
ex_hi  in  DATA_W  HI write data
ex_lo  in  DATA_W  LO write data
hilo_temp_i  in  2*DATA_W  EX partial product/accumulator
cnt_i  in  CNT_W  EX multi-cycle step index
mem_wd  out  ADDR_W  registered ex_wd
mem_wreg  out  1  registered ex_wreg
mem_wdata  out  DATA_W  registered ex_wdata
mem_whilo  out  1  registered ex_whilo
mem_hi  out  DATA_W  registered ex_hi
mem_lo  out  DATA_W  registered ex_lo
mem_valid  out  1  1 = MEM holds a real instruction, 0 = bubble
hilo_temp_o  out  2*DATA_W  loop-back of hilo_temp_i to EX
cnt_o  out  CNT_W  loop-back of cnt_i to EX

Behaviour:
- All updates occur on posedge clk only. Latency EX->MEM is 1 cycle. No combinational path from any input to any output.
- Reset (rst=1): all outputs 0. mem_wd=NOPRegAddr, mem_wreg=mem_whilo=WriteDisable, data=ZeroWord, mem_valid=0.
- Priority, highest first: rst > flush > stall cases > normal.
- flush=1: load a bubble (all mem_* = 0, mem_valid=0) and clear hilo_temp_o/cnt_o. Flush overrides any stall.
- ex stalled, mem not stalled (stall[EX]=1, stall[MEM]=0):
  - insert a bubble into MEM (same values as flush)
  - hilo_temp_o<=hilo_temp_i and cnt_o<=cnt_i, so EX resumes its multi-cycle op next cycle
- ex stalled, mem stalled (stall[EX]=1, stall[MEM]=1): hold every register, including loop-back.
- stall[EX]=0, stall[MEM]=1 is illegal: ctrl never issues it. Treat it as hold. In simulation, flag it with an assertion.
- Normal (stall[EX]=0): capture all ex_* fields, mem_valid=1, hilo_temp_o=0, cnt_o=0.
- cnt is not incremented here. EX owns the arithmetic; this block only stores it. Wrap is EX's concern.
- Reset mid multi-cycle op: loop-back cleared. EX must restart the op from cnt=0.

Optional Feature:
Macro EX_MEM_BUBBLE_CNT_EN.
- Defined:
  - adds output bubble_cnt [31:0]
  - increments by 1 on every cycle a bubble is loaded (flush or EX-stall-only case)
  - saturates at 32'hFFFF_FFFF
  - cleared by rst
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared define include supplies RstEnable, WriteDisable, ZeroWord, NOPRegAddr, and the stall-index localparams.
- One natural sub-module, pipe_bubble_reg: a generic width-parameterised register with hold/bubble/load controls. Instantiate it for the writeback descriptor and the HI/LO triple. Keep the loop-back registers in the top block.

Test Plan:
1. Reset: rst=1 for 2 cycles with nonzero inputs -> all outputs 0, mem_valid=0.
2. Normal flow: ex_wd=5'd8, ex_wreg=1, ex_wdata=32'h1234_5678, stall=0 -> next cycle mem_wd=8, mem_wdata=32'h1234_5678, mem_valid=1, cnt_o=0.
3. EX stall: stall=6'b001111, hilo_temp_i=64'hA5, cnt_i=2'd1 -> mem_wreg=0, mem_valid=0, hilo_temp_o=64'hA5, cnt_o=1.
4. Full hold: stall=6'b011111 after case 2 -> all outputs unchanged for 3 cycles.
5. Flush vs stall: flush=1, stall=6'b001111, cnt_i=2'd1 -> bubble with cnt_o=0, hilo_temp_o=0.
6. HI/LO path: ex_whilo=1, ex_hi=32'hDEAD_BEEF, ex_lo=32'h0000_0001 -> next cycle mem_whilo=1 with matching mem_hi/mem_lo. With EX_MEM_BUBBLE_CNT_EN: 3 stall bubbles followed by 1 flush -> bubble_cnt=4.
